// File: rtl/vaddr_offset_scheduler.sv
// Collects distinct NDP offsets for one batch into a small table, then issues them
// one at a time to the NDP engine, waiting for each completion before the next.
module vaddr_offset_scheduler #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              offset_valid,
    input  logic [ADDR_W-1:0] offset,
    input  logic              commit,
    input  logic              abort,
    output logic              ndp_req_valid,
    input  logic              ndp_req_ready,
    output logic [ADDR_W-1:0] ndp_req_offset,
    output logic [IDX_W-1:0]  ndp_req_idx,
    input  logic              ndp_done,
    output logic              batch_done,
    output logic              busy,
    output logic [IDX_W:0]    entry_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT,
        FINISH
    } state_t;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   table_data [DEPTH];
    logic [DEPTH-1:0]    table_valid;
    logic [IDX_W:0]      count;
    logic [IDX_W-1:0]    ptr;
    logic                overflow_q;

    logic                hit;
    logic                full;
    logic                capture;
    logic                drop_full;
    logic [IDX_W:0]      count_after;
    logic                last_entry;

    // Duplicate detection over the full offset width against every live entry.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (table_valid[i] && (table_data[i] == offset)) begin
                hit = 1'b1;
            end
        end
    end

    assign full        = (count == FULL_COUNT);
    assign capture     = (state == IDLE) && offset_valid && !full && !hit;
    assign drop_full   = (state == IDLE) && offset_valid && full;
    assign count_after = count + (IDX_W+1)'(capture);
    assign last_entry  = ({1'b0, ptr} == (count - (IDX_W+1)'(1)));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_next = (count_after != '0) ? DISPATCH : FINISH;
                end
            end
            DISPATCH: begin
                if (ndp_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ndp_done) begin
                    state_next = last_entry ? FINISH : DISPATCH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Offset storage carries no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (capture && !abort) begin
            table_data[count[IDX_W-1:0]] <= offset;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            table_valid <= '0;
            count       <= '0;
            ptr         <= '0;
            overflow_q  <= 1'b0;
        end else if (abort) begin
            table_valid <= '0;
            count       <= '0;
            ptr         <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        table_valid[count[IDX_W-1:0]] <= 1'b1;
                        count                         <= count_after;
                    end
                    if (drop_full) begin
                        overflow_q <= 1'b1;
                    end
                    if (commit) begin
                        ptr <= '0;
                    end
                end
                WAIT: begin
                    if (ndp_done && !last_entry) begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                FINISH: begin
                    table_valid <= '0;
                    count       <= '0;
                    ptr         <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Request outputs are decoded from state so they idle at zero outside DISPATCH.
    assign ndp_req_valid  = (state == DISPATCH);
    assign ndp_req_offset = (state == DISPATCH) ? table_data[ptr] : '0;
    assign ndp_req_idx    = (state == DISPATCH) ? ptr : '0;
    assign batch_done     = (state == FINISH);
    assign busy           = (state != IDLE);
    assign entry_count    = count;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_vaddr_offset_scheduler.sv
// Directed bench for vaddr_offset_scheduler: a queue-based batch model checked every
// cycle, plus literal expectations for each scenario.
module tb_vaddr_offset_scheduler;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_FIN  = 3;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              offset_valid = 1'b0;
    logic [ADDR_W-1:0] offset = '0;
    logic              commit = 1'b0;
    logic              abort = 1'b0;
    logic              ndp_req_valid;
    logic              ndp_req_ready = 1'b0;
    logic [ADDR_W-1:0] ndp_req_offset;
    logic [IDX_W-1:0]  ndp_req_idx;
    logic              ndp_done = 1'b0;
    logic              batch_done;
    logic              busy;
    logic [IDX_W:0]    entry_count;
    logic              overflow;

    vaddr_offset_scheduler #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .offset_valid  (offset_valid),
        .offset        (offset),
        .commit        (commit),
        .abort         (abort),
        .ndp_req_valid (ndp_req_valid),
        .ndp_req_ready (ndp_req_ready),
        .ndp_req_offset(ndp_req_offset),
        .ndp_req_idx   (ndp_req_idx),
        .ndp_done      (ndp_done),
        .batch_done    (batch_done),
        .busy          (busy),
        .entry_count   (entry_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Batch model: the captured list, a cursor into it, and the current phase.
    logic [ADDR_W-1:0] mCap[$];
    int                mPtr = 0;
    int                mPhase = PH_IDLE;
    bit                mOvf = 1'b0;
    bit                mSeen;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn || abort) begin
            mCap.delete();
            mPtr   = 0;
            mPhase = PH_IDLE;
            mOvf   = 1'b0;
        end else begin
            case (mPhase)
                PH_IDLE: begin
                    if (offset_valid) begin
                        mSeen = 1'b0;
                        foreach (mCap[i]) if (mCap[i] == offset) mSeen = 1'b1;
                        if (mCap.size() == DEPTH) mOvf = 1'b1;
                        else if (!mSeen) mCap.push_back(offset);
                    end
                    if (commit) begin
                        mPtr   = 0;
                        mPhase = (mCap.size() > 0) ? PH_REQ : PH_FIN;
                    end
                end
                PH_REQ: if (ndp_req_ready) mPhase = PH_WAIT;
                PH_WAIT: begin
                    if (ndp_done) begin
                        if (mPtr == mCap.size() - 1) mPhase = PH_FIN;
                        else begin
                            mPtr++;
                            mPhase = PH_REQ;
                        end
                    end
                end
                default: begin
                    mCap.delete();
                    mPtr   = 0;
                    mPhase = PH_IDLE;
                end
            endcase
        end
    end

    logic [ADDR_W-1:0] reqOff[$];
    logic [IDX_W-1:0]  reqIdx[$];
    int                bdCount = 0;

    always @(negedge clk) begin
        if (ndp_req_valid && ndp_req_ready) begin
            reqOff.push_back(ndp_req_offset);
            reqIdx.push_back(ndp_req_idx);
        end
        if (batch_done) bdCount++;
    end

    always @(negedge clk) begin
        checkOutput("mdl_req_valid", 64'(ndp_req_valid), 64'(mPhase == PH_REQ));
        if (mPhase == PH_REQ) begin
            checkOutput("mdl_req_offset", ndp_req_offset, mCap[mPtr]);
            checkOutput("mdl_req_idx", 64'(ndp_req_idx), 64'(mPtr));
        end
        checkOutput("mdl_batch_done", 64'(batch_done), 64'(mPhase == PH_FIN));
        checkOutput("mdl_busy", 64'(busy), 64'(mPhase != PH_IDLE));
        checkOutput("mdl_entry_count", 64'(entry_count), 64'(mCap.size()));
        checkOutput("mdl_overflow", 64'(overflow), 64'(mOvf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ov, input logic [ADDR_W-1:0] off, input logic cm, input logic ab);
        offset_valid = ov;
        offset       = off;
        commit       = cm;
        abort        = ab;
        tick();
        offset_valid = 1'b0;
        offset       = '0;
        commit       = 1'b0;
        abort        = 1'b0;
    endtask

    // Plays the engine: accept each request after readyLag cycles, complete after doneLag.
    task automatic serveBatch(input int n, input int readyLag, input int doneLag);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (!ndp_req_valid && t < 50) begin
                tick();
                t++;
            end
            if (!ndp_req_valid) begin
                checkOutput("req_timeout", 64'(ndp_req_valid), 64'd1);
                return;
            end
            repeat (readyLag) tick();
            ndp_req_ready = 1'b1;
            tick();
            ndp_req_ready = 1'b0;
            repeat (doneLag) tick();
            ndp_done = 1'b1;
            tick();
            ndp_done = 1'b0;
        end
    endtask

    initial begin
        #500000;
        checkOutput("watchdog", 64'd0, 64'd1);
        $fatal(1, "[TB] watchdog expired");
    end

    int base;
    int bd0;

    initial begin
        repeat (2) tick();
        checkOutput("rst_entry_count", 64'(entry_count), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_req_valid", 64'(ndp_req_valid), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_batch_done", 64'(batch_done), 64'd0);
        checkOutput("rst_req_offset", ndp_req_offset, 64'd0);
        aresetn = 1'b1;
        tick();

        $display("[TB] two-entry batch");
        applyStimulus(1'b1, 64'h100, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h200, 1'b0, 1'b0);
        checkOutput("t1_count", 64'(entry_count), 64'd2);
        base = reqOff.size();
        bd0  = bdCount;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        serveBatch(2, 0, 2);
        repeat (3) tick();
        checkOutput("t1_nreq", 64'(reqOff.size() - base), 64'd2);
        checkOutput("t1_req0_off", reqOff[base], 64'h100);
        checkOutput("t1_req0_idx", 64'(reqIdx[base]), 64'd0);
        checkOutput("t1_req1_off", reqOff[base+1], 64'h200);
        checkOutput("t1_req1_idx", 64'(reqIdx[base+1]), 64'd1);
        checkOutput("t1_batch_done_once", 64'(bdCount - bd0), 64'd1);
        checkOutput("t1_count_clear", 64'(entry_count), 64'd0);

        $display("[TB] duplicate drop");
        applyStimulus(1'b1, 64'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h80, 1'b0, 1'b0);
        checkOutput("t2_count", 64'(entry_count), 64'd2);
        checkOutput("t2_overflow", 64'(overflow), 64'd0);
        base = reqOff.size();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        serveBatch(2, 0, 1);
        repeat (3) tick();
        checkOutput("t2_req0_off", reqOff[base], 64'h40);
        checkOutput("t2_req1_off", reqOff[base+1], 64'h80);

        $display("[TB] overflow");
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 64'(k * 'h1000), 1'b0, 1'b0);
        checkOutput("t3_count", 64'(entry_count), 64'd4);
        checkOutput("t3_overflow", 64'(overflow), 64'd1);
        base = reqOff.size();
        bd0  = bdCount;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        serveBatch(4, 0, 1);
        repeat (3) tick();
        checkOutput("t3_nreq", 64'(reqOff.size() - base), 64'd4);
        checkOutput("t3_req3_off", reqOff[base+3], 64'h4000);
        checkOutput("t3_req3_idx", 64'(reqIdx[base+3]), 64'd3);
        checkOutput("t3_batch_done", 64'(bdCount - bd0), 64'd1);
        checkOutput("t3_overflow_sticky", 64'(overflow), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t3_overflow_abort", 64'(overflow), 64'd0);

        $display("[TB] ready stall");
        applyStimulus(1'b1, 64'h777, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t4_valid_start", 64'(ndp_req_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            offset_valid = 1'b1;
            offset       = 64'h999;
            tick();
            checkOutput("t4_hold_valid", 64'(ndp_req_valid), 64'd1);
            checkOutput("t4_hold_offset", ndp_req_offset, 64'h777);
        end
        offset_valid  = 1'b0;
        offset        = '0;
        ndp_req_ready = 1'b1;
        tick();
        ndp_req_ready = 1'b0;
        checkOutput("t4_wait_valid", 64'(ndp_req_valid), 64'd0);
        checkOutput("t4_wait_busy", 64'(busy), 64'd1);
        checkOutput("t4_ignored_capture", 64'(entry_count), 64'd1);
        repeat (2) tick();
        ndp_done = 1'b1;
        tick();
        ndp_done = 1'b0;
        checkOutput("t4_batch_done", 64'(batch_done), 64'd1);
        tick();

        $display("[TB] empty commit and commit with capture");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_empty_done", 64'(batch_done), 64'd1);
        checkOutput("t5_empty_valid", 64'(ndp_req_valid), 64'd0);
        tick();
        checkOutput("t5_empty_done_pulse", 64'(batch_done), 64'd0);
        checkOutput("t5_empty_idle", 64'(busy), 64'd0);
        base = reqOff.size();
        applyStimulus(1'b1, 64'h300, 1'b1, 1'b0);
        checkOutput("t5_cc_count", 64'(entry_count), 64'd1);
        checkOutput("t5_cc_valid", 64'(ndp_req_valid), 64'd1);
        checkOutput("t5_cc_offset", ndp_req_offset, 64'h300);
        serveBatch(1, 0, 0);
        repeat (2) tick();
        checkOutput("t5_cc_nreq", 64'(reqOff.size() - base), 64'd1);

        $display("[TB] abort in wait");
        applyStimulus(1'b1, 64'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h600, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        ndp_req_ready = 1'b1;
        tick();
        ndp_req_ready = 1'b0;
        base = reqOff.size();
        bd0  = bdCount;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t6_abort_idle", 64'(busy), 64'd0);
        checkOutput("t6_abort_count", 64'(entry_count), 64'd0);
        ndp_done = 1'b1;
        tick();
        ndp_done = 1'b0;
        repeat (3) tick();
        checkOutput("t6_no_req", 64'(ndp_req_valid), 64'd0);
        checkOutput("t6_no_batch_done", 64'(bdCount - bd0), 64'd0);
        checkOutput("t6_no_new_accept", 64'(reqOff.size() - base), 64'd0);

        $display("[TB] reset in dispatch");
        applyStimulus(1'b1, 64'hABC, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t7_pre_valid", 64'(ndp_req_valid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("t7_async_valid", 64'(ndp_req_valid), 64'd0);
        checkOutput("t7_async_busy", 64'(busy), 64'd0);
        checkOutput("t7_async_count", 64'(entry_count), 64'd0);
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        applyStimulus(1'b1, 64'h10, 1'b0, 1'b0);
        checkOutput("t7_post_capture", 64'(entry_count), 64'd1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vaddr_offset_scheduler.md
# vaddr_offset_scheduler

Collects the distinct virtual-address offsets presented for one near-data-processing (NDP) batch into a small table, then dispatches them one at a time to the NDP engine over a valid/ready request channel. Each entry waits for the engine's completion before the next is issued, and the block pulses `batch_done` when the batch is retired. It sits between the offset producer (address decode) and the NDP engine, generalising two-slot offset tracking to a parameterised, sequenced queue.

## Interface
- `ADDR_W`, 64, offset width.
- `DEPTH`, 4, table entries; power of two, 2..16.
- `IDX_W`, $clog2(DEPTH), entry index width (derived, do not override).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `offset_valid`  in  1  capture strobe for `offset`.
- `offset`  in  ADDR_W  offset to capture.
- `commit`  in  1  closes the batch and starts dispatch.
- `abort`  in  1  synchronous flush of batch and table.
- `ndp_req_valid`  out  1  request to the NDP engine.
- `ndp_req_ready`  in  1  engine accepts the request.
- `ndp_req_offset`  out  ADDR_W  offset of the current request.
- `ndp_req_idx`  out  IDX_W  table index of the current request.
- `ndp_done`  in  1  single-cycle completion of the accepted request.
- `batch_done`  out  1  one-cycle pulse when the batch is retired.
- `busy`  out  1  high whenever state is not IDLE.
- `entry_count`  out  IDX_W+1  number of valid table entries.
- `overflow`  out  1  sticky flag: a capture was dropped because the table was full.

## Operation
- FSM states: IDLE, DISPATCH, WAIT, FINISH. All outputs are registered or derived from state; they are Moore-type.
- Capture happens only in IDLE. If `offset_valid` is high, the table is not full, and `offset` does not match any valid entry, the offset is written at index `entry_count`, its valid bit is set, and the count is incremented.
  - A duplicate offset is dropped silently.
  - When the table is full (count == DEPTH), the offset is dropped and `overflow` is set.
  - `offset_valid` outside IDLE is ignored and does not set `overflow`.
- IDLE and `commit`: a capture in the same cycle is applied first and is included in the batch. The next state is DISPATCH if the resulting count is greater than 0, otherwise FINISH. The pointer is reset to 0.
- DISPATCH: `ndp_req_valid` = 1, `ndp_req_offset` = table[ptr], `ndp_req_idx` = ptr.
  - These outputs stay stable until `ndp_req_ready` is sampled high.
  - On valid && ready, the next state is WAIT.
- WAIT: `ndp_req_valid` = 0. On `ndp_done`:
  - if ptr == count-1, go to FINISH;
  - otherwise increment ptr and go to DISPATCH.
  - `ndp_done` in any other state is ignored.
- FINISH: `batch_done` = 1 for exactly one cycle. All valid bits, the count and ptr are cleared, and the next state is IDLE. `overflow` is not cleared here.
- `abort`: valid in any state and has highest priority. The next state is IDLE; valid bits, count, ptr and `overflow` are cleared. No `batch_done` is produced. A request already accepted by the engine is abandoned; its later `ndp_done` is ignored because the block is in IDLE.
- `overflow` is cleared only by reset or `abort`.
- Arithmetic:
  - the count saturates at DEPTH, so it never wraps;
  - ptr never exceeds count-1;
  - the offset comparison uses the full ADDR_W bits.

## Timing
- Reset values:
  - state IDLE;
  - `ndp_req_valid`, `batch_done`, `busy`, `overflow` = 0;
  - `ndp_req_offset` = 0, `ndp_req_idx` = 0, `entry_count` = 0;
  - table valid bits 0. Table data need not be reset.
- Capture latency: `offset_valid` at edge T is reflected in `entry_count` after T.
- `commit` sampled at T: `ndp_req_valid` is high from T+1.
- Handshake at T: WAIT from T+1.
- `ndp_done` at T: the next request is valid at T+1, or `batch_done` is high at T+1.
- `busy` is high from the cycle after `commit` through the FINISH cycle.
- Minimum batch turnaround with one entry, ready held high and done returned immediately: 3 cycles from `commit` to `batch_done`.
- Empty commit: `batch_done` one cycle after `commit`.
- `aresetn` asserted mid-batch: outputs go to their reset values immediately (asynchronously). Deassertion is synchronised externally.

## Test plan
- Capture 0x100, 0x200, then commit; ready held high; done 2 cycles after each accept -> requests (idx 0, 0x100) then (1, 0x200); `batch_done` pulses once; `entry_count` returns to 0.
- Capture 0x40 twice, then 0x80 -> `entry_count` = 2, `overflow` = 0; dispatch order is 0x40, 0x80.
- DEPTH=4, capture 5 distinct offsets -> `entry_count` = 4, `overflow` = 1 and stays 1 after `batch_done`; cleared by `abort`.
- Hold `ndp_req_ready` low for 5 cycles in DISPATCH -> `ndp_req_valid` and `ndp_req_offset` stay constant; WAIT is entered the cycle after ready rises.
- `commit` with an empty table -> `batch_done` the next cycle, `ndp_req_valid` never asserted. `commit` and `offset_valid` = 0x300 in the same cycle -> single request with 0x300.
- `abort` in WAIT with a later `ndp_done` -> no `batch_done`, no new request. Reset asserted in DISPATCH -> `ndp_req_valid` = 0 immediately.
